weight_stream_loader: RTL and testbench

- Consumer end of the coefficient stream produced by the per-layer weight streamers.
- Pops `MEM_SIZE` coefficients from an ap_fifo-style stream (dout/empty_n/read) into a local RAM.
- Once loaded, presents a 1-cycle-latency random-access read port, with the same addr/ce/q shape as the layer ROMs, to the convolution datapath.
- Supports reloading on request for layer re-use.

---
 rtl/weight_stream_loader_pkg.sv | 15 +
 rtl/weight_ram_sp.sv | 39 +++
 rtl/weight_stream_loader.sv | 144 ++++++++++++++
 tb/tb_weight_stream_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_loader_pkg.sv
// Shared defaults for the coefficient stream loader and its RAM.
// Includes the helper that derives the address width from the memory depth.
package weight_stream_loader_pkg;

    localparam int COEFF_WIDTH_DEF = 16;
    localparam int MEM_SIZE_DEF    = 288;

    // Address width for a memory of the given depth, never narrower than one bit
    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/weight_ram_sp.sv
// Simple dual-port coefficient RAM with one write port and one registered read port.
// It has no reset, so it can be inferred as block RAM.
module weight_ram_sp
    import weight_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH = COEFF_WIDTH_DEF,
    parameter int DEPTH      = MEM_SIZE_DEF,
    parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Write port: callers guarantee waddr < DEPTH whenever we=1
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    // Registered read port: q holds its value while re=0
    always_ff @(posedge clk) begin
        if (re) begin
            q <= mem_r[raddr];
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Loads MEM_SIZE coefficients from an ap_fifo stream into local RAM.
// Once loaded, the RAM is exposed as a 1-cycle-latency addr/ce/q read port.
module weight_stream_loader
    import weight_stream_loader_pkg::*;
#(
    parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int MEM_SIZE    = MEM_SIZE_DEF,
    parameter int ADDR_WIDTH  = addr_width(MEM_SIZE)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [COEFF_WIDTH-1:0] input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    input  logic                   reload,
    output logic                   loaded,
    output logic                   load_done,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_ce,
    output logic [COEFF_WIDTH-1:0] rd_q
);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_EXT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    state_t                 state_r;
    state_t                 next_state_s;
    logic [ADDR_WIDTH-1:0]  wr_cnt_r;
    logic                   loaded_r;
    logic                   load_done_r;
    logic                   rd_valid_r;
    logic                   rd_in_range_s;
    logic                   pop_s;
    logic                   last_pop_s;
    logic [COEFF_WIDTH-1:0] ram_q_s;

    assign rd_in_range_s = ({1'b0, rd_addr} < MEM_SIZE_EXT);
    assign last_pop_s    = pop_s && (wr_cnt_r == LAST_ADDR);

    // Next state and stream pop; reload overrides completion of the final word
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_LOAD: begin
                pop_s = input_V_empty_n;
                if (reload) begin
                    next_state_s = ST_LOAD;
                end else if (last_pop_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_READY: begin
                if (reload) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_READY;
                end
            end
            default: begin
                next_state_s = ST_LOAD;
                pop_s        = 1'b0;
            end
        endcase
    end

    // State register, write counter and load status flags
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r     <= ST_LOAD;
            wr_cnt_r    <= {ADDR_WIDTH{1'b0}};
            loaded_r    <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            load_done_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (reload) begin
                        wr_cnt_r <= {ADDR_WIDTH{1'b0}};
                    end else if (last_pop_s) begin
                        wr_cnt_r    <= {ADDR_WIDTH{1'b0}};
                        loaded_r    <= 1'b1;
                        load_done_r <= 1'b1;
                    end else if (pop_s) begin
                        wr_cnt_r <= wr_cnt_r + ADDR_WIDTH'(1);
                    end else begin
                        wr_cnt_r <= wr_cnt_r;
                    end
                end
                ST_READY: begin
                    if (reload) begin
                        wr_cnt_r <= {ADDR_WIDTH{1'b0}};
                        loaded_r <= 1'b0;
                    end else begin
                        wr_cnt_r <= wr_cnt_r;
                    end
                end
                default: begin
                    wr_cnt_r <= {ADDR_WIDTH{1'b0}};
                    loaded_r <= 1'b0;
                end
            endcase
        end
    end

    // Read gate: loaded is sampled on the same edge as the address
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_valid_r <= 1'b0;
        end else if (rd_ce) begin
            rd_valid_r <= loaded_r && rd_in_range_s;
        end else begin
            rd_valid_r <= rd_valid_r;
        end
    end

    weight_ram_sp #(
        .DATA_WIDTH (COEFF_WIDTH),
        .DEPTH      (MEM_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (ap_clk),
        .we    (pop_s),
        .waddr (wr_cnt_r),
        .wdata (input_V_dout),
        .re    (rd_ce && rd_in_range_s),
        .raddr (rd_addr),
        .q     (ram_q_s)
    );

    assign input_V_read = pop_s;
    assign loaded       = loaded_r;
    assign load_done    = load_done_r;
    assign rd_q         = rd_valid_r ? ram_q_s : {COEFF_WIDTH{1'b0}};

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed test of weight_stream_loader with MEM_SIZE=4, using a 3-bit read address
// so that out-of-range addresses can be reached.
module tb_weight_stream_loader;

    localparam int CW = 16;
    localparam int MS = 4;
    localparam int AW = 3;

    logic          ap_clk;
    logic          ap_rst;
    logic [CW-1:0] input_V_dout;
    logic          input_V_empty_n;
    logic          input_V_read;
    logic          reload;
    logic          loaded;
    logic          load_done;
    logic [AW-1:0] rd_addr;
    logic          rd_ce;
    logic [CW-1:0] rd_q;

    int n_vec = 0;
    int n_err = 0;

    weight_stream_loader #(
        .COEFF_WIDTH (CW),
        .MEM_SIZE    (MS),
        .ADDR_WIDTH  (AW)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .input_V_dout    (input_V_dout),
        .input_V_empty_n (input_V_empty_n),
        .input_V_read    (input_V_read),
        .reload          (reload),
        .loaded          (loaded),
        .load_done       (load_done),
        .rd_addr         (rd_addr),
        .rd_ce           (rd_ce),
        .rd_q            (rd_q)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] set_a [4];
        logic [15:0] set_b [4];
        logic [15:0] set_c [4];
        logic [15:0] set_d [4];
        logic [6:0]  pat;
        int          k;

        set_a = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        set_b = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        set_c = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
        set_d = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};

        ap_rst          = 1'b1;
        input_V_dout    = 16'h0000;
        input_V_empty_n = 1'b0;
        reload          = 1'b0;
        rd_addr         = 3'd0;
        rd_ce           = 1'b0;
        @(negedge ap_clk);
        tick();
        tick();
        ap_rst = 1'b0;
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_rd_q", 32'(rd_q), 32'd0);
        chk("rst_read_idle", 32'(input_V_read), 32'd0);

        // Read during LOAD returns zero
        rd_addr = 3'd2;
        rd_ce   = 1'b1;
        tick();
        rd_ce = 1'b0;
        chk("rd_before_loaded", 32'(rd_q), 32'd0);

        // Back-to-back load of set A
        for (int i = 0; i < 4; i++) begin
            input_V_dout    = set_a[i];
            input_V_empty_n = 1'b1;
            #1;
            chk($sformatf("a_read_%0d", i), 32'(input_V_read), 32'd1);
            tick();
            chk($sformatf("a_done_%0d", i), 32'(load_done), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("a_loaded", 32'(loaded), 32'd1);
        input_V_dout = 16'hDEAD;
        #1;
        chk("a_no_pop_ready", 32'(input_V_read), 32'd0);
        tick();
        chk("a_done_pulse_end", 32'(load_done), 32'd0);
        chk("a_loaded_holds", 32'(loaded), 32'd1);
        input_V_empty_n = 1'b0;

        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            rd_ce   = 1'b1;
            tick();
            chk($sformatf("a_rd_%0d", i), 32'(rd_q), 32'(set_a[i]));
        end

        // Out-of-range read, then hold with ce=0
        rd_addr = 3'd5;
        tick();
        chk("rd_oob", 32'(rd_q), 32'd0);
        rd_addr = 3'd1;
        tick();
        chk("rd_addr1", 32'(rd_q), 32'h0022);
        rd_ce   = 1'b0;
        rd_addr = 3'd3;
        tick();
        chk("rd_hold", 32'(rd_q), 32'h0022);

        // Reload from READY, then stalled stream of set B
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("b_reload_unloaded", 32'(loaded), 32'd0);
        pat = 7'b1011001;  // bit i applies to step i: 1,0,0,1,1,0,1
        k   = 0;
        for (int i = 0; i < 7; i++) begin
            input_V_empty_n = pat[i];
            input_V_dout    = pat[i] ? set_b[k] : 16'hDEAD;
            if (i == 6) begin
                rd_addr = 3'd0;
                rd_ce   = 1'b1;
            end
            #1;
            chk($sformatf("b_read_%0d", i), 32'(input_V_read), 32'(pat[i]));
            tick();
            if (pat[i]) k++;
            chk($sformatf("b_done_%0d", i), 32'(load_done), (i == 6) ? 32'd1 : 32'd0);
        end
        input_V_empty_n = 1'b0;
        chk("b_loaded", 32'(loaded), 32'd1);
        chk("b_rd_on_done_edge", 32'(rd_q), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            tick();
            chk($sformatf("b_rd_%0d", i), 32'(rd_q), 32'(set_b[i]));
        end
        rd_ce = 1'b0;

        // Reload coinciding with the fourth pop
        reload = 1'b1;
        tick();
        reload = 1'b0;
        input_V_empty_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input_V_dout = 16'h1111 * 16'(i + 1);
            tick();
        end
        input_V_dout = 16'h4444;
        reload       = 1'b1;
        tick();
        reload = 1'b0;
        chk("c_no_done", 32'(load_done), 32'd0);
        chk("c_not_loaded", 32'(loaded), 32'd0);
        #1;
        chk("c_still_load", 32'(input_V_read), 32'd1);
        for (int i = 0; i < 4; i++) begin
            input_V_dout = set_c[i];
            tick();
            chk($sformatf("c_done_%0d", i), 32'(load_done), (i == 3) ? 32'd1 : 32'd0);
        end
        input_V_empty_n = 1'b0;
        rd_ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            tick();
            chk($sformatf("c_rd_%0d", i), 32'(rd_q), 32'(set_c[i]));
        end
        rd_ce = 1'b0;
        chk("c_rd_q_nonzero", 32'(rd_q), 32'h8888);

        // Reset after two pops abandons the partial set
        reload = 1'b1;
        tick();
        reload          = 1'b0;
        input_V_empty_n = 1'b1;
        input_V_dout    = 16'h9999;
        tick();
        input_V_dout = 16'hAAAA;
        tick();
        input_V_empty_n = 1'b0;
        ap_rst          = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("d_rst_loaded", 32'(loaded), 32'd0);
        chk("d_rst_rd_q", 32'(rd_q), 32'd0);
        chk("d_rst_done", 32'(load_done), 32'd0);
        input_V_empty_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            input_V_dout = set_d[i];
            tick();
            chk($sformatf("d_done_%0d", i), 32'(load_done), (i == 3) ? 32'd1 : 32'd0);
        end
        input_V_empty_n = 1'b0;
        chk("d_loaded", 32'(loaded), 32'd1);
        rd_ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            tick();
            chk($sformatf("d_rd_%0d", i), 32'(rd_q), 32'(set_d[i]));
        end
        rd_ce = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
